byte_gather: RTL and testbench

Receive-side counterpart of the PUF response serializer. It watches a start strobe and a `BITS`-wide byte stream and reassembles `DATA_BITS/BITS` consecutive bytes, MSB-byte first, into one `DATA_BITS`-wide word. It presents that word with a one-cycle valid pulse. It sits at the far end of the byte link, for example on the host/UART side or in the PUF loopback test path, and connects directly to the serializer's `start_out`/`b_out`.

---
 rtl/byte_gather.sv | 100 ++++++++++
 tb/tb_byte_gather.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/byte_gather.sv
// byte_gather: reassembles a start-framed, one-symbol-per-clock byte stream
// (MSB byte first) into one DATA_BITS-wide word with a single-cycle valid pulse.
// A new start strobe in the middle of a frame aborts it and flags err.
module byte_gather #(
    parameter int DATA_BITS = 264,
    parameter int BITS      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_in,
    input  logic [BITS-1:0]      b_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 busy,
    output logic                 err
);

    localparam int COUNT = DATA_BITS / BITS;
    localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             counter_q, counter_d;
    logic [DATA_BITS-1:0]   acc_q, acc_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [DATA_BITS-1:0]   acc_shift;

    // Accumulator with the incoming symbol appended at the LSB end; older
    // bytes migrate toward the MSB so byte 0 lands in the top slot.
    assign acc_shift = {acc_q[DATA_BITS-BITS-1:0], b_in};

    // State and datapath registers; everything clears as soon as rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= 8'd0;
            acc_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: pulses default low, restart beats completion.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    acc_d     = acc_shift;
                    counter_d = 8'd1;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                acc_d = acc_shift;
                if (start_in) begin
                    // Partial frame dropped; this symbol is byte 0 of a new one.
                    err_d     = 1'b1;
                    counter_d = 8'd1;
                end else if (counter_q == LAST_IDX) begin
                    data_d    = acc_shift;
                    valid_d   = 1'b1;
                    counter_d = 8'd0;
                    state_d   = IDLE;
                end else begin
                    counter_d = counter_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = 8'd0;
            end
        endcase
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign err       = err_q;
    assign busy      = (state_q == COLLECT);

endmodule

// File: tb/tb_byte_gather.sv
// Testbench for byte_gather: directed frames plus a serializer-style loopback,
// with expected words/err cycles queued by the driver and checked by a monitor.
module tb_byte_gather;

    localparam int DB  = 264;
    localparam int B   = 8;
    localparam int CNT = DB / B;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_in;
    logic [B-1:0]  b_in;
    logic [DB-1:0] data_out;
    logic          valid_out;
    logic          busy;
    logic          err;

    byte_gather #(.DATA_BITS(DB), .BITS(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_in  (start_in),
        .b_in      (b_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DB-1:0] data;
    } exp_t;

    exp_t vq[$];
    int   eq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void check(string name, logic [DB-1:0] act, logic [DB-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endfunction

    // Monitor: every valid_out / err pulse must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        int   ec;
        if (rst_n) begin
            if (valid_out) begin
                if (vq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid cycle %0d", cyc);
                end else begin
                    e = vq.pop_front();
                    check("valid_cycle", DB'(cyc), DB'(e.cyc));
                    check("data_out", data_out, e.data);
                    $display("[TB] word at cycle %0d: %0h", cyc, data_out);
                end
            end
            if (err) begin
                if (eq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_err cycle %0d", cyc);
                end else begin
                    ec = eq.pop_front();
                    check("err_cycle", DB'(cyc), DB'(ec));
                    $display("[TB] err at cycle %0d", cyc);
                end
            end
        end
    end

    // Drive nbytes of word w starting with start_in on byte 0.
    task automatic drive_frame(input logic [DB-1:0] w, input int nbytes,
                               input bit push, input bit chk_busy);
        int c0;
        exp_t e;
        c0 = cyc;
        if (push) begin
            e.cyc  = c0 + CNT;
            e.data = w;
            vq.push_back(e);
        end
        for (int k = 0; k < nbytes; k++) begin
            start_in = (k == 0);
            b_in     = w[DB-1-k*B -: B];
            @(posedge clk);
            #1;
            if (chk_busy) check("busy", DB'(busy), DB'((k + 1) < CNT));
        end
        start_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start_in = 1'b0;
            b_in     = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  data_out, '0);
        check({tag, "_valid"}, DB'(valid_out), '0);
        check({tag, "_busy"},  DB'(busy), '0);
        check({tag, "_err"},   DB'(err), '0);
    endtask

    logic [DB-1:0] w1, wa, wb, wo, wr, wp, wc, wl;

    initial begin
        rst_n    = 1'b0;
        start_in = 1'b0;
        b_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Idle noise: bytes without start must not disturb anything.
        idle(100);
        check_all_zero("idle");

        // Single frame 0x01..0x21, busy checked each cycle.
        w1 = '0;
        for (int k = 0; k < CNT; k++) w1 = {w1[DB-B-1:0], 8'(k + 1)};
        drive_frame(w1, CNT, 1'b1, 1'b1);
        idle(2);
        check("hold_single", data_out, w1);

        // Back-to-back frames: second start coincides with first valid.
        wa = {CNT{8'hAA}};
        wb = {CNT{8'h55}};
        drive_frame(wa, CNT, 1'b1, 1'b0);
        drive_frame(wb, CNT, 1'b1, 1'b0);
        idle(2);

        // Restart at byte 10 of a partial frame.
        for (int k = 0; k < CNT; k++) wo = {wo[DB-B-1:0], 8'(8'h10 + k)};
        for (int k = 0; k < CNT; k++) wr = {wr[DB-B-1:0], 8'(8'h80 + k)};
        drive_frame(wo, 10, 1'b0, 1'b0);
        check("hold_before_restart", data_out, wb);
        eq.push_back(cyc + 1);
        drive_frame(wr, 5, 1'b1, 1'b0);
        check("hold_after_err", data_out, wb);
        check("busy_restart", DB'(busy), DB'(1));
        // Remaining bytes of the restarted frame (no new start).
        for (int k = 5; k < CNT; k++) begin
            b_in = wr[DB-1-k*B -: B];
            @(posedge clk);
            #1;
        end
        idle(2);
        check("hold_restart", data_out, wr);

        // Asynchronous reset mid-frame (cycle 15), then a clean frame.
        for (int k = 0; k < CNT; k++) wp = {wp[DB-B-1:0], 8'(8'hC0 + k)};
        drive_frame(wp, 15, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < CNT; k++) wc = {wc[DB-B-1:0], 8'(8'h3C ^ k)};
        drive_frame(wc, CNT, 1'b1, 1'b0);
        idle(2);

        // Loopback with a serializer-style source: random words, small gaps.
        for (int i = 0; i < 1000; i++) begin
            for (int j = 0; j < 9; j++) wl = {wl[DB-33:0], $urandom};
            drive_frame(wl, CNT, 1'b1, 1'b0);
            idle(1 + int'($urandom_range(0, 1)));
        end
        idle(3);

        check("valid_queue_empty", DB'(vq.size()), '0);
        check("err_queue_empty", DB'(eq.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
